// File: rtl/countdown_bcd_if.sv
// Control/status bundle between game logic (master) and the BCD countdown timer (slave).
// Digit 0 occupies the least-significant field of every multi-digit bus.
interface countdown_bcd_if #(
  parameter int DIGITS = 2
);
  logic                  iLOAD;
  logic                  iLOAD_SEL;
  logic [4*DIGITS-1:0]   iLOAD_VAL;
  logic                  iRUN;
  logic                  iHOLD;
  logic                  iAUTO;
  logic [4*DIGITS-1:0]   oBCD;
  logic [7*DIGITS-1:0]   oHEX;
  logic                  oTICK;
  logic                  oWRAP;
  logic                  oEXPIRED;

  modport master (
    output iLOAD, iLOAD_SEL, iLOAD_VAL, iRUN, iHOLD, iAUTO,
    input  oBCD, oHEX, oTICK, oWRAP, oEXPIRED
  );

  modport slave (
    input  iLOAD, iLOAD_SEL, iLOAD_VAL, iRUN, iHOLD, iAUTO,
    output oBCD, oHEX, oTICK, oWRAP, oEXPIRED
  );
endinterface

// File: rtl/countdown_bcd.sv
// N-digit BCD countdown timer with prescaled tick, hold/pause, one-shot or auto-reload,
// and active-low seven-segment decode of every digit.
module countdown_bcd #(
  parameter int                  DIGITS    = 2,
  parameter int                  TICK_DIV  = 50_000_000,
  parameter logic [4*DIGITS-1:0] START_BCD = 'h60
) (
  input  logic            iCLK,
  input  logic            iRST_N,
  countdown_bcd_if.slave  bus
);
  localparam int BW = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_EXPIRED
  } state_t;

  function automatic logic [BW-1:0] clamp_bcd(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
    end
    return r;
  endfunction

  // Ripple borrow: a zero digit becomes 9 and passes the borrow upward.
  function automatic logic [BW-1:0] dec_bcd(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  localparam logic [BW-1:0] START_CLAMPED = clamp_bcd(START_BCD);

  state_t         state_q, state_d;
  logic [BW-1:0]  bcd_q, bcd_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic           tick_q, tick_d;
  logic           wrap_q, wrap_d;
  logic           expired_q, expired_d;
  logic [BW-1:0]  load_src;
  logic           count_en;

  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    presc_d   = presc_q;
    tick_d    = 1'b0;
    wrap_d    = 1'b0;
    expired_d = expired_q;
    load_src  = bus.iLOAD_SEL ? bus.iLOAD_VAL : START_BCD;
    count_en  = bus.iRUN & ~bus.iHOLD;

    if (bus.iLOAD) begin
      state_d   = S_IDLE;
      bcd_d     = clamp_bcd(load_src);
      presc_d   = '0;
      expired_d = 1'b0;
    end else if (state_q != S_EXPIRED) begin
      if (!count_en) begin
        // Prescaler is left untouched so a resumed count keeps its partial period.
        if (state_q == S_RUN) begin
          state_d = S_PAUSE;
        end
      end else begin
        state_d = S_RUN;
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          tick_d  = 1'b1;
          if (bcd_q == '0) begin
            if (bus.iAUTO) begin
              bcd_d  = START_CLAMPED;
              wrap_d = 1'b1;
            end else begin
              state_d   = S_EXPIRED;
              expired_d = 1'b1;
            end
          end else begin
            bcd_d = dec_bcd(bcd_q);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= S_IDLE;
      bcd_q     <= START_CLAMPED;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
      expired_q <= expired_d;
    end
  end

  assign bus.oBCD     = bcd_q;
  assign bus.oTICK    = tick_q;
  assign bus.oWRAP    = wrap_q;
  assign bus.oEXPIRED = expired_q;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_hex
    assign bus.oHEX[7*gi +: 7] = seg7(bcd_q[4*gi +: 4]);
  end
endmodule

// File: tb/tb_countdown_bcd.sv
// Bench for countdown_bcd: integer-valued reference model checked every cycle,
// directed scenarios with literal expectations, then randomized control traffic.
module tb_countdown_bcd;
  localparam int D  = 2;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  countdown_bcd_if #(.DIGITS(D)) bus ();

  countdown_bcd #(
    .DIGITS   (D),
    .TICK_DIV (TD),
    .START_BCD(8'h12)
  ) dut (
    .iCLK  (clk),
    .iRST_N(rst_n),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_val(input logic [7:0] v);
    int hi, lo;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > 9) hi = 9;
    if (lo > 9) lo = 9;
    return hi * 10 + lo;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg(input int d);
    logic [6:0] t [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return t[d];
  endfunction

  // Reference model: value as a plain integer, phase as cycles into the current period.
  int m_val, m_phase;
  bit m_exp, m_tick, m_wrap;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_val = 12; m_phase = 0; m_exp = 0; m_tick = 0; m_wrap = 0;
    end else begin
      m_tick = 0;
      m_wrap = 0;
      if (bus.iLOAD) begin
        m_val   = clamp_val(bus.iLOAD_SEL ? bus.iLOAD_VAL : 8'h12);
        m_phase = 0;
        m_exp   = 0;
      end else if (!m_exp && bus.iRUN && !bus.iHOLD) begin
        if (m_phase == TD - 1) begin
          m_phase = 0;
          m_tick  = 1;
          if (m_val == 0) begin
            if (bus.iAUTO) begin
              m_val  = 12;
              m_wrap = 1;
            end else begin
              m_exp = 1;
            end
          end else begin
            m_val = m_val - 1;
          end
        end else begin
          m_phase = m_phase + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("bcd",     32'(bus.oBCD),     32'(to_bcd(m_val)));
      check("hex",     32'(bus.oHEX),     32'({seg(m_val / 10), seg(m_val % 10)}));
      check("tick",    32'(bus.oTICK),    32'(m_tick));
      check("wrap",    32'(bus.oWRAP),    32'(m_wrap));
      check("expired", 32'(bus.oEXPIRED), 32'(m_exp));
    end
  end

  int  n;
  bit  seen;

  initial begin
    rst_n = 1'b0;
    bus.iLOAD = 0; bus.iLOAD_SEL = 0; bus.iLOAD_VAL = '0;
    bus.iRUN = 0;  bus.iHOLD = 0;     bus.iAUTO = 0;
    #23;
    check("rst_bcd",  32'(bus.oBCD), 32'h12);
    check("rst_hex",  32'(bus.oHEX), 32'({7'h79, 7'h24}));
    check("rst_flags", 32'({bus.oTICK, bus.oWRAP, bus.oEXPIRED}), 32'h0);
    rst_n  = 1'b1;
    chk_en = 1;
    @(posedge clk); #1;

    // One-shot countdown 12 -> 00 -> expired.
    bus.iRUN = 1;
    seen = 0; n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.oBCD == 8'h10 && !seen) begin
        seen = 1;
        check("hex_10", 32'(bus.oHEX), 32'({7'h79, 7'h40}));
      end
      if (bus.oEXPIRED) begin n = i; break; end
    end
    check("expire_cycles", 32'(n), 32'd53);
    check("expire_bcd", 32'(bus.oBCD), 32'h00);
    repeat (5) @(negedge clk);
    check("expired_hold", 32'(bus.oEXPIRED), 32'd1);

    // Reload default from EXPIRED, this time in auto-reload mode.
    @(posedge clk); #1;
    bus.iLOAD = 1; bus.iLOAD_SEL = 0; bus.iAUTO = 1;
    @(posedge clk); #1;
    bus.iLOAD = 0;
    check("load_clr_exp", 32'(bus.oEXPIRED), 32'd0);
    check("load_bcd", 32'(bus.oBCD), 32'h12);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.oWRAP) begin n = i; break; end
    end
    check("wrap_cycles", 32'(n), 32'd53);
    check("wrap_bcd", 32'(bus.oBCD), 32'h12);
    check("wrap_tick", 32'(bus.oTICK), 32'd1);
    check("wrap_noexp", 32'(bus.oEXPIRED), 32'd0);

    // Hold at 07 with two cycles of partial period banked.
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_val == 7 && m_phase == 2) begin seen = 1; break; end
    end
    check("reach_07", 32'(seen), 32'd1);
    bus.iHOLD = 1;
    repeat (10) @(posedge clk);
    #1;
    check("hold_bcd", 32'(bus.oBCD), 32'h07);
    bus.iHOLD = 0;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (bus.oTICK) begin n = i; break; end
    end
    check("resume_latency", 32'(n), 32'd2);
    check("resume_bcd", 32'(bus.oBCD), 32'h06);

    // Runtime load with clamping, then a load landing on a tick edge.
    bus.iLOAD = 1; bus.iLOAD_SEL = 1; bus.iLOAD_VAL = 8'hA5;
    @(posedge clk); #1;
    bus.iLOAD = 0;
    check("load_a5", 32'(bus.oBCD), 32'h95);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_phase == TD - 1) begin seen = 1; break; end
    end
    check("reach_tick_edge", 32'(seen), 32'd1);
    bus.iLOAD = 1; bus.iLOAD_VAL = 8'h3C;
    @(posedge clk); #1;
    bus.iLOAD = 0;
    check("load_on_tick_notick", 32'(bus.oTICK), 32'd0);
    check("load_on_tick_bcd", 32'(bus.oBCD), 32'h39);

    // Randomized control traffic.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      bus.iLOAD     = ($urandom_range(0, 15) == 0);
      bus.iLOAD_SEL = 1'($urandom_range(0, 1));
      bus.iLOAD_VAL = 8'($urandom_range(0, 255));
      bus.iRUN      = ($urandom_range(0, 7) != 0);
      bus.iHOLD     = ($urandom_range(0, 7) == 0);
      bus.iAUTO     = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    bus.iLOAD = 0; bus.iHOLD = 0; bus.iRUN = 1; bus.iAUTO = 1;
    repeat (7) @(posedge clk);

    // Asynchronous reset between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_bcd",  32'(bus.oBCD), 32'h12);
    check("arst_hex",  32'(bus.oHEX), 32'({7'h79, 7'h24}));
    check("arst_flags", 32'({bus.oTICK, bus.oWRAP, bus.oEXPIRED}), 32'h0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
